// File: rtl/hub75_fb_writer_if.sv
// Raster pixel-stream handshake between an upstream source and hub75_fb_writer.
// The source drives data/SOF/VALID; the writer answers with READY.
interface hub75_fb_writer_if #(
    parameter int PIXEL_DEPTH = 3
) ();
    logic [3*PIXEL_DEPTH-1:0] PIX_DATA;
    logic                     PIX_SOF;
    logic                     PIX_VALID;
    logic                     PIX_READY;

    modport master (output PIX_DATA, PIX_SOF, PIX_VALID, input PIX_READY);
    modport slave  (input PIX_DATA, PIX_SOF, PIX_VALID, output PIX_READY);
endinterface

// File: rtl/hub75_fb_writer.sv
// Writes a raster RGB stream into the HUB75 display RAM, two pixels per word
// (upper-half row in the high half, lower-half row in the low half) via read-modify-write.
module hub75_fb_writer #(
    parameter int PIXEL_DEPTH     = 3,
    parameter int PANELS_NUM      = 2,
    parameter int PANEL_WIDTH     = 8,
    parameter int MULTIPLEX_RATIO = 4,
    parameter int MEM_DATA_WIDTH  = 18,
    parameter int MEM_ADDR_WIDTH  = 6
) (
    input  logic                      CLK,
    input  logic                      RESET,
    hub75_fb_writer_if.slave          pix,
    output logic [MEM_ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [MEM_DATA_WIDTH-1:0] RD_DATA,
    output logic [MEM_ADDR_WIDTH-1:0] WR_ADDR,
    output logic [MEM_DATA_WIDTH-1:0] WR_DATA,
    output logic                      WR_EN,
    output logic                      FRAME_DONE,
    output logic                      ERR_SOF
);
    localparam int LINE   = PANELS_NUM * PANEL_WIDTH;
    localparam int ROWS   = 2 * MULTIPLEX_RATIO;
    localparam int X_W    = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int Y_W    = $clog2(ROWS);
    localparam int HALF_W = MEM_DATA_WIDTH / 2;
    localparam int PIX_W  = 3 * PIXEL_DEPTH;

    typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE} state_t;

    state_t                    state_q, state_d;
    logic [X_W-1:0]            x_q, x_d;
    logic [Y_W-1:0]            y_q, y_d;
    logic                      last_q, last_d;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [MEM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                      wr_en_q, wr_en_d;
    logic                      frame_done_q, frame_done_d;
    logic                      err_sof_q, err_sof_d;
    logic [PIX_W-1:0]          pix_q, pix_d;
    logic                      half_q, half_d;

    logic                      pix_ready;
    logic                      accept;
    logic [X_W-1:0]            cur_x;
    logic [Y_W-1:0]            cur_y;
    logic [Y_W-1:0]            cur_rp;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr;

    // READY is gated by RESET so no pixel can be accepted during a reset cycle.
    assign pix_ready     = (state_q == IDLE) && !RESET;
    assign pix.PIX_READY = pix_ready;
    assign accept        = pix_ready && pix.PIX_VALID;

    // An accepted SOF pins the pixel to (0,0) whatever the counters say.
    always_comb begin
        cur_x    = pix.PIX_SOF ? '0 : x_q;
        cur_y    = pix.PIX_SOF ? '0 : y_q;
        cur_rp   = (cur_y >= Y_W'(MULTIPLEX_RATIO)) ? cur_y - Y_W'(MULTIPLEX_RATIO) : cur_y;
        cur_addr = MEM_ADDR_WIDTH'(cur_rp) * MEM_ADDR_WIDTH'(LINE) + MEM_ADDR_WIDTH'(cur_x);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        last_d       = last_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        err_sof_d    = 1'b0;
        pix_d        = pix_q;
        half_d       = half_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pix_d     = pix.PIX_DATA;
                    half_d    = (cur_y >= Y_W'(MULTIPLEX_RATIO));
                    rd_addr_d = cur_addr;
                    last_d    = (cur_x == X_W'(LINE - 1)) && (cur_y == Y_W'(ROWS - 1));
                    err_sof_d = pix.PIX_SOF && ((x_q != '0) || (y_q != '0));
                    if (cur_x == X_W'(LINE - 1)) begin
                        x_d = '0;
                        y_d = (cur_y == Y_W'(ROWS - 1)) ? '0 : cur_y + Y_W'(1);
                    end else begin
                        x_d = cur_x + X_W'(1);
                        y_d = cur_y;
                    end
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: state_d = MERGE;
            MERGE: begin
                // rd_addr_q still holds this pixel's address, so it doubles as the write address.
                wr_data_d    = half_q ? {RD_DATA[MEM_DATA_WIDTH-1:HALF_W], pix_q}
                                      : {pix_q, RD_DATA[HALF_W-1:0]};
                wr_addr_d    = rd_addr_q;
                wr_en_d      = 1'b1;
                frame_done_d = last_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            last_q       <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            last_q       <= last_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    always_ff @(posedge CLK) begin
        pix_q  <= pix_d;
        half_q <= half_d;
    end

    assign RD_ADDR    = rd_addr_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign WR_EN      = wr_en_q;
    assign FRAME_DONE = frame_done_q;
    assign ERR_SOF    = err_sof_q;
endmodule

// File: tb/tb_hub75_fb_writer.sv
// Self-checking bench for hub75_fb_writer: RAM model, scoreboard of expected writes,
// and one task per scenario.
`timescale 1ns/1ps
module tb_hub75_fb_writer;
    localparam int PD   = 3;
    localparam int PN   = 2;
    localparam int PW   = 8;
    localparam int MR   = 4;
    localparam int DW   = 18;
    localparam int AW   = 6;
    localparam int LINE = PN * PW;
    localparam int ROWS = 2 * MR;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, wr_data;
    logic          wr_en, frame_done, err_sof;

    hub75_fb_writer_if #(.PIXEL_DEPTH(PD)) pix_if ();

    hub75_fb_writer #(
        .PIXEL_DEPTH(PD), .PANELS_NUM(PN), .PANEL_WIDTH(PW),
        .MULTIPLEX_RATIO(MR), .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)
    ) dut (
        .CLK(clk), .RESET(rst), .pix(pix_if),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_EN(wr_en),
        .FRAME_DONE(frame_done), .ERR_SOF(err_sof)
    );

    always #5 clk = ~clk;

    // Display RAM: registered read, write on WR_EN, plus bench preload/clear ports.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic          ram_clr = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data <= ram[rd_addr];
        if (ram_clr) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
        end else begin
            if (pre_en) ram[pre_addr] <= pre_data;
            if (wr_en === 1'b1) ram[wr_addr] <= wr_data;
        end
    end

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    int            mx = 0, my = 0, exp_err = 0;
    int            hs_cyc = -100;
    int            wr_cnt = 0, fd_cnt = 0, err_cnt = 0;
    int            fd_addr = -1, err_cyc = -1, last_wr_addr = -1;
    logic [DW-1:0] last_wr_data = '0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (cyc - hs_cyc <= 1) begin
                    checks++;
                    if (pix_if.PIX_READY !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_busy: ready=%b want 0, %0d cycles after handshake", pix_if.PIX_READY, cyc - hs_cyc);
                    end
                end
                if (wr_en === 1'b1) begin
                    wr_cnt++;
                    last_wr_addr = int'(wr_addr);
                    last_wr_data = wr_data;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%0d data=%h, want no write", wr_addr, wr_data);
                    end else begin
                        e = sb.pop_front();
                        if (wr_addr !== AW'(e.addr) || wr_data !== e.data || frame_done !== e.last || (cyc - hs_cyc) != 2) begin
                            errors++;
                            $display("FAIL write: addr=%0d data=%h fd=%b lat=%0d, want addr=%0d data=%h fd=%b lat=2",
                                     wr_addr, wr_data, frame_done, cyc - hs_cyc, e.addr, e.data, e.last);
                        end
                    end
                end else if (frame_done === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done_no_write: frame_done=1 with wr_en=%b, want 0", wr_en);
                end
                if (frame_done === 1'b1) begin
                    fd_cnt++;
                    fd_addr = int'(wr_addr);
                end
                if (err_sof === 1'b1) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
            end
        end
    endtask

    task automatic send_pixel(input logic [8:0] d, input logic sof);
        int a;
        bit h, last, ok;
        logic [DW-1:0] w;
        if (sof) begin
            if (mx != 0 || my != 0) exp_err++;
            mx = 0;
            my = 0;
        end
        a    = (my % MR) * LINE + mx;
        h    = (my >= MR);
        last = (mx == LINE - 1) && (my == ROWS - 1);
        w    = model_mem[a];
        if (h) w[8:0] = d;
        else   w[17:9] = d;
        pix_if.PIX_VALID = 1'b1;
        pix_if.PIX_DATA  = d;
        pix_if.PIX_SOF   = sof;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (pix_if.PIX_READY === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout: ready=%b, want 1 within 50 cycles", pix_if.PIX_READY);
            pix_if.PIX_VALID = 1'b0;
        end else begin
            model_mem[a] = w;
            sb.push_back('{a, w, last});
            hs_cyc = cyc;
            if (mx == LINE - 1) begin
                mx = 0;
                my = (my == ROWS - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        pix_if.PIX_SOF = 1'b0;
    endtask

    task automatic drain();
        pix_if.PIX_VALID = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic preload(input int a, input logic [DW-1:0] v);
        pre_addr     = AW'(a);
        pre_data     = v;
        pre_en       = 1'b1;
        model_mem[a] = v;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ram_clr = 1'b1;
        pix_if.PIX_VALID = 1'b0;
        pix_if.PIX_SOF   = 1'b0;
        pix_if.PIX_DATA  = '0;
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_if.PIX_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready=%b want 0", pix_if.PIX_READY);
        end
        checks++;
        if ({wr_en, frame_done, err_sof} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: wr_en/fd/err=%b want 000", {wr_en, frame_done, err_sof});
        end
        checks++;
        if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: rd_addr=%0d wr_addr=%0d wr_data=%h want 0 0 0", rd_addr, wr_addr, wr_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_if.PIX_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%b want 1", pix_if.PIX_READY);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_upper_half();
        int base;
        drain();
        preload(0, 18'h3FFFF);
        base = wr_cnt;
        send_pixel({3'd5, 3'd2, 3'd7}, 1'b1);
        drain();
        checks++;
        if (wr_cnt - base != 1 || last_wr_addr != 0 || last_wr_data !== 18'h2AFFF) begin
            errors++;
            $display("FAIL upper_half: writes=%0d addr=%0d data=%h, want 1 0 2afff", wr_cnt - base, last_wr_addr, last_wr_data);
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL upper_half_err: err_sof pulses=%0d want 0", err_cnt);
        end
    endtask

    task automatic test_lower_merge();
        for (int i = 0; i < 66; i++) send_pixel(9'($urandom_range(0, 511)), 1'b0);
        drain();
        preload(3, 18'h2AA00);
        send_pixel({3'd1, 3'd1, 3'd1}, 1'b0);
        drain();
        checks++;
        if (last_wr_addr != 3 || last_wr_data !== 18'h2AA49) begin
            errors++;
            $display("FAIL lower_merge: addr=%0d data=%h, want 3 2aa49", last_wr_addr, last_wr_data);
        end
        for (int i = 0; i < 60; i++) send_pixel(9'($urandom_range(0, 511)), 1'b0);
        drain();
    endtask

    task automatic test_full_frame();
        int base_wr, base_fd, first_hs, last_hs;
        base_wr = wr_cnt;
        base_fd = fd_cnt;
        send_pixel(9'($urandom_range(0, 511)), 1'b1);
        first_hs = hs_cyc;
        for (int i = 1; i < LINE * ROWS; i++) send_pixel(9'($urandom_range(0, 511)), 1'b0);
        last_hs = hs_cyc;
        drain();
        checks++;
        if (wr_cnt - base_wr != 128) begin
            errors++;
            $display("FAIL frame_writes: got %0d want 128", wr_cnt - base_wr);
        end
        checks++;
        if (fd_cnt - base_fd != 1 || fd_addr != 63) begin
            errors++;
            $display("FAIL frame_done: pulses=%0d addr=%0d, want 1 63", fd_cnt - base_fd, fd_addr);
        end
        checks++;
        if (last_hs - first_hs != 127 * 3) begin
            errors++;
            $display("FAIL throughput: span=%0d cycles want %0d", last_hs - first_hs, 127 * 3);
        end
        send_pixel(9'($urandom_range(0, 511)), 1'b0);
        drain();
        checks++;
        if (last_wr_addr != 0 || err_cnt != exp_err) begin
            errors++;
            $display("FAIL frame_wrap: addr=%0d err=%0d, want 0 %0d", last_wr_addr, err_cnt, exp_err);
        end
    endtask

    task automatic test_sof_mid_frame();
        int e0, sof_hs;
        logic [8:0] d;
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) send_pixel(9'($urandom_range(0, 511)), 1'b0);
        d = 9'($urandom_range(0, 511));
        send_pixel(d, 1'b1);
        sof_hs = hs_cyc;
        send_pixel(9'($urandom_range(0, 511)), 1'b0);
        drain();
        checks++;
        if (err_cnt - e0 != 1 || err_cyc != sof_hs) begin
            errors++;
            $display("FAIL err_sof: pulses=%0d at +%0d, want 1 at +0", err_cnt - e0, err_cyc - sof_hs);
        end
        checks++;
        if (ram[0][17:9] !== d || last_wr_addr != 1) begin
            errors++;
            $display("FAIL sof_restart: ram0_hi=%h last_addr=%0d, want %h 1", ram[0][17:9], last_wr_addr, d);
        end
    endtask

    task automatic test_backpressure();
        int base, gap;
        base = wr_cnt;
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                pix_if.PIX_VALID = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    pix_if.PIX_SOF  = 1'($urandom_range(0, 1));
                    pix_if.PIX_DATA = 9'($urandom_range(0, 511));
                    @(posedge clk);
                    #1;
                end
            end
            send_pixel(9'($urandom_range(0, 511)), 1'b0);
        end
        drain();
        checks++;
        if (wr_cnt - base != 40 || err_cnt != exp_err) begin
            errors++;
            $display("FAIL backpressure: writes=%0d err=%0d, want 40 %0d", wr_cnt - base, err_cnt, exp_err);
        end
    endtask

    task automatic test_reset_rd_wait();
        int base, e0;
        bit ok;
        base = wr_cnt;
        pix_if.PIX_VALID = 1'b1;
        pix_if.PIX_SOF   = 1'b0;
        pix_if.PIX_DATA  = 9'h1FF;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (pix_if.PIX_READY === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        pix_if.PIX_VALID = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || pix_if.PIX_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_rd_wait_ready: accepted=%0d ready=%b, want 1 0", ok, pix_if.PIX_READY);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        hs_cyc = -100;
        mx = 0;
        my = 0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != base || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_rd_wait_write: writes=%0d wr_en=%b, want 0 0", wr_cnt - base, wr_en);
        end
        e0 = err_cnt;
        send_pixel(9'($urandom_range(0, 511)), 1'b1);
        drain();
        checks++;
        if (wr_cnt - base != 1 || last_wr_addr != 0 || err_cnt != e0) begin
            errors++;
            $display("FAIL rst_rd_wait_sof: writes=%0d addr=%0d err=%0d, want 1 0 0", wr_cnt - base, last_wr_addr, err_cnt - e0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_upper_half();
        test_lower_merge();
        test_full_frame();
        test_sof_mid_frame();
        test_backpressure();
        test_reset_rd_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
